// File: rtl/wb_arbiter_pkg.sv
// Shared widths, constants and source encoding for the register-file writeback arbiter.
package wb_arbiter_pkg;
  localparam int RegNumLog2 = 5;
  localparam int RegAddrBus = RegNumLog2;
  localparam int RegBus     = 32;
  localparam logic WriteEnable = 1'b1;
  localparam logic [RegBus-1:0] ZeroWord = '0;

  // Used both as the grant selector and as the age flag (value = older buffer).
  // Age resets to WbSrcLsu, which is also the tie-break for same-edge entries.
  typedef enum logic {
    WbSrcLsu  = 1'b0,
    WbSrcPipe = 1'b1
  } wb_src_e;

  // When both buffers match a query, the newer entry wins.
  function automatic logic fwd_pick_pipe(input logic p_match, input logic l_match,
                                         input wb_src_e older);
    return p_match && (!l_match || older == WbSrcLsu);
  endfunction
endpackage

// File: rtl/wb_hold_buf.sv
// One-entry writeback holding buffer with two forwarding address comparators.
module wb_hold_buf
  import wb_arbiter_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegAddrBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic              clear,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] q_addr1,
  input  logic [ADDR_W-1:0] q_addr2,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              match1,
  output logic              match2
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (accept && in_addr != '0) begin
      valid <= 1'b1;
      addr  <= in_addr;
      data  <= in_data;
    end else if (clear || accept) begin
      // x0 writes are swallowed: the slot is left empty
      valid <= 1'b0;
    end
  end

  assign match1 = valid && q_addr1 != '0 && addr == q_addr1;
  assign match2 = valid && q_addr2 != '0 && addr == q_addr2;
endmodule

// File: rtl/wb_arbiter.sv
// Arbitrates the register file write port between pipeline and LSU writebacks,
// oldest-first, with forwarding of still-buffered results to decode.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegAddrBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              pipe_valid,
  output logic              pipe_ready,
  input  logic [ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_waddr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] q_addr1,
  output logic              q_hit1,
  output logic [DATA_W-1:0] q_data1,
  input  logic [ADDR_W-1:0] q_addr2,
  output logic              q_hit2,
  output logic [DATA_W-1:0] q_data2,
  output logic              idle
);
  logic              p_vld, l_vld;
  logic [ADDR_W-1:0] p_addr, l_addr;
  logic [DATA_W-1:0] p_data, l_data;
  logic              p_m1, p_m2, l_m1, l_m2;
  logic              gnt_vld, p_gnt, l_gnt;
  wb_src_e           gnt_src, age, age_nxt;
  logic              p_acc, l_acc, p_in, l_in, p_nv, l_nv;

  always_comb begin
    gnt_vld = p_vld || l_vld;
    gnt_src = WbSrcLsu;
    if (p_vld && l_vld) gnt_src = age;
    else if (p_vld)     gnt_src = WbSrcPipe;
  end

  assign p_gnt = gnt_vld && gnt_src == WbSrcPipe;
  assign l_gnt = gnt_vld && gnt_src == WbSrcLsu;

  assign pipe_ready = !rst && rdy && (!p_vld || p_gnt);
  assign lsu_ready  = !rst && rdy && (!l_vld || l_gnt);
  assign p_acc      = pipe_valid && pipe_ready;
  assign l_acc      = lsu_valid && lsu_ready;
  assign p_in       = p_acc && pipe_waddr != '0;
  assign l_in       = l_acc && lsu_waddr != '0;

  wb_hold_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_pipe_buf (
    .clk(clk), .rst(rst), .accept(p_acc), .clear(rdy && p_gnt),
    .in_addr(pipe_waddr), .in_data(pipe_wdata), .q_addr1(q_addr1), .q_addr2(q_addr2),
    .valid(p_vld), .addr(p_addr), .data(p_data), .match1(p_m1), .match2(p_m2)
  );

  wb_hold_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lsu_buf (
    .clk(clk), .rst(rst), .accept(l_acc), .clear(rdy && l_gnt),
    .in_addr(lsu_waddr), .in_data(lsu_wdata), .q_addr1(q_addr1), .q_addr2(q_addr2),
    .valid(l_vld), .addr(l_addr), .data(l_data), .match1(l_m1), .match2(l_m2)
  );

  // Occupancy after this edge decides the age: an entry arriving next to a
  // surviving entry is the newer one; two arrivals at once tie to LSU-older.
  always_comb begin
    p_nv    = p_in || (p_vld && !(rdy && p_gnt));
    l_nv    = l_in || (l_vld && !(rdy && l_gnt));
    age_nxt = age;
    if (!p_nv || !l_nv)   age_nxt = WbSrcLsu;
    else if (l_in && !p_in) age_nxt = WbSrcPipe;
    else if (p_in)          age_nxt = WbSrcLsu;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age   <= WbSrcLsu;
      we    <= 1'b0;
      waddr <= '0;
      wdata <= DATA_W'(ZeroWord);
    end else if (rdy) begin
      age <= age_nxt;
      if (gnt_vld) begin
        we    <= WriteEnable;
        waddr <= p_gnt ? p_addr : l_addr;
        wdata <= p_gnt ? p_data : l_data;
      end else begin
        we <= 1'b0;
      end
    end
  end

  always_comb begin
    q_hit1  = !rst && (p_m1 || l_m1);
    q_hit2  = !rst && (p_m2 || l_m2);
    q_data1 = '0;
    q_data2 = '0;
    if (!rst) begin
      if (fwd_pick_pipe(p_m1, l_m1, age)) q_data1 = p_data;
      else if (l_m1)                      q_data1 = l_data;
      if (fwd_pick_pipe(p_m2, l_m2, age)) q_data2 = p_data;
      else if (l_m2)                      q_data2 = l_data;
    end
  end

  assign idle = !p_vld && !l_vld && !we;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed-vector bench for wb_arbiter: ordering, forwarding, x0 discard and rdy freeze.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        pipe_valid, pipe_ready, lsu_valid, lsu_ready;
  logic [4:0]  pipe_waddr, lsu_waddr, waddr, q_addr1, q_addr2;
  logic [31:0] pipe_wdata, lsu_wdata, wdata, q_data1, q_data2;
  logic        we, q_hit1, q_hit2, idle;
  int          n_cmp = 0;
  int          n_err = 0;

  wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
    .we(we), .waddr(waddr), .wdata(wdata),
    .q_addr1(q_addr1), .q_hit1(q_hit1), .q_data1(q_data1),
    .q_addr2(q_addr2), .q_hit2(q_hit2), .q_data2(q_data2),
    .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pipe(input logic v, input logic [4:0] a, input logic [31:0] d);
    pipe_valid = v; pipe_waddr = a; pipe_wdata = d;
  endtask

  task automatic drive_lsu(input logic v, input logic [4:0] a, input logic [31:0] d);
    lsu_valid = v; lsu_waddr = a; lsu_wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; q_addr1 = '0; q_addr2 = '0;
    drive_pipe(0, 0, 0); drive_lsu(0, 0, 0);
    tick(); tick();
    n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL rst_we got %0b want 0", we); end
    n_cmp++; if (waddr !== 5'd0 || wdata !== 32'd0) begin n_err++; $display("FAIL rst_wdata got %0d/%h want 0/0", waddr, wdata); end
    n_cmp++; if (pipe_ready !== 1'b0 || lsu_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %0b%0b want 00", pipe_ready, lsu_ready); end
    rst = 1'b0; #1;
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL rst_idle got %0b want 1", idle); end
    n_cmp++; if (pipe_ready !== 1'b1 || lsu_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after got %0b%0b want 11", pipe_ready, lsu_ready); end
  endtask

  task automatic test_reset_mid_op();
    drive_pipe(1, 5'd1, 32'h11); drive_lsu(1, 5'd2, 32'h22);
    tick();
    drive_pipe(0, 0, 0); drive_lsu(0, 0, 0);
    q_addr1 = 5'd1; #1;
    n_cmp++; if (q_hit1 !== 1'b1 || q_data1 !== 32'h11) begin n_err++; $display("FAIL mid_fwd got %0b/%h want 1/11", q_hit1, q_data1); end
    rst = 1'b1; #1;
    n_cmp++; if (q_hit1 !== 1'b0 || q_data1 !== 32'd0) begin n_err++; $display("FAIL mid_rst_fwd got %0b/%h want 0/0", q_hit1, q_data1); end
    tick();
    rst = 1'b0; #1;
    n_cmp++; if (we !== 1'b0 || idle !== 1'b1) begin n_err++; $display("FAIL mid_rst_state got we=%0b idle=%0b want 0/1", we, idle); end
    n_cmp++; if (pipe_ready !== 1'b1 || lsu_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready got %0b%0b want 11", pipe_ready, lsu_ready); end
    tick();
    n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL mid_rst_nowrite got %0b want 0", we); end
    q_addr1 = '0;
  endtask

  task automatic test_lone_pipe();
    drive_pipe(1, 5'd5, 32'h0000_1234); #1;
    n_cmp++; if (pipe_ready !== 1'b1) begin n_err++; $display("FAIL lone_ready got %0b want 1", pipe_ready); end
    tick();
    drive_pipe(0, 0, 0); q_addr2 = 5'd5; #1;
    n_cmp++; if (we !== 1'b0 || idle !== 1'b0) begin n_err++; $display("FAIL lone_n got we=%0b idle=%0b want 0/0", we, idle); end
    n_cmp++; if (q_hit2 !== 1'b1 || q_data2 !== 32'h1234) begin n_err++; $display("FAIL lone_fwd got %0b/%h want 1/1234", q_hit2, q_data2); end
    tick();
    n_cmp++; if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'h1234) begin n_err++; $display("FAIL lone_write got %0b/%0d/%h want 1/5/1234", we, waddr, wdata); end
    n_cmp++; if (q_hit2 !== 1'b0) begin n_err++; $display("FAIL lone_fwd_gone got %0b want 0", q_hit2); end
    tick();
    n_cmp++; if (we !== 1'b0 || idle !== 1'b1 || waddr !== 5'd5) begin n_err++; $display("FAIL lone_done got %0b/%0b/%0d want 0/1/5", we, idle, waddr); end
    q_addr2 = '0;
  endtask

  task automatic test_contention();
    drive_pipe(1, 5'd3, 32'hAAAA); drive_lsu(1, 5'd3, 32'hBBBB);
    tick();
    drive_pipe(0, 0, 0); drive_lsu(0, 0, 0); q_addr1 = 5'd3; #1;
    n_cmp++; if (q_hit1 !== 1'b1 || q_data1 !== 32'hAAAA) begin n_err++; $display("FAIL cont_fwd0 got %0b/%h want 1/aaaa", q_hit1, q_data1); end
    n_cmp++; if (pipe_ready !== 1'b0 || lsu_ready !== 1'b1) begin n_err++; $display("FAIL cont_ready got %0b%0b want 01", pipe_ready, lsu_ready); end
    tick();
    n_cmp++; if (we !== 1'b1 || waddr !== 5'd3 || wdata !== 32'hBBBB) begin n_err++; $display("FAIL cont_first got %0b/%0d/%h want 1/3/bbbb", we, waddr, wdata); end
    n_cmp++; if (q_hit1 !== 1'b1 || q_data1 !== 32'hAAAA) begin n_err++; $display("FAIL cont_gap got %0b/%h want 1/aaaa", q_hit1, q_data1); end
    tick();
    n_cmp++; if (we !== 1'b1 || waddr !== 5'd3 || wdata !== 32'hAAAA) begin n_err++; $display("FAIL cont_second got %0b/%0d/%h want 1/3/aaaa", we, waddr, wdata); end
    tick();
    n_cmp++; if (we !== 1'b0 || idle !== 1'b1) begin n_err++; $display("FAIL cont_done got %0b/%0b want 0/1", we, idle); end
    q_addr1 = '0;
  endtask

  task automatic test_oldest_first();
    drive_pipe(1, 5'd1, 32'h11); drive_lsu(1, 5'd7, 32'h1);
    tick();
    drive_pipe(1, 5'd8, 32'h2); drive_lsu(1, 5'd9, 32'h99); #1;
    n_cmp++; if (pipe_ready !== 1'b0 || lsu_ready !== 1'b1) begin n_err++; $display("FAIL old_ready0 got %0b%0b want 01", pipe_ready, lsu_ready); end
    tick();
    drive_lsu(0, 0, 0); #1;
    n_cmp++; if (we !== 1'b1 || waddr !== 5'd7 || wdata !== 32'h1) begin n_err++; $display("FAIL old_w0 got %0b/%0d/%h want 1/7/1", we, waddr, wdata); end
    n_cmp++; if (pipe_ready !== 1'b1 || lsu_ready !== 1'b0) begin n_err++; $display("FAIL old_ready1 got %0b%0b want 10", pipe_ready, lsu_ready); end
    tick();
    drive_pipe(0, 0, 0); #1;
    n_cmp++; if (we !== 1'b1 || waddr !== 5'd1 || wdata !== 32'h11) begin n_err++; $display("FAIL old_w1 got %0b/%0d/%h want 1/1/11", we, waddr, wdata); end
    tick();
    n_cmp++; if (we !== 1'b1 || waddr !== 5'd9 || wdata !== 32'h99) begin n_err++; $display("FAIL old_w2 got %0b/%0d/%h want 1/9/99", we, waddr, wdata); end
    tick();
    n_cmp++; if (we !== 1'b1 || waddr !== 5'd8 || wdata !== 32'h2) begin n_err++; $display("FAIL old_w3 got %0b/%0d/%h want 1/8/2", we, waddr, wdata); end
    tick();
    n_cmp++; if (we !== 1'b0 || idle !== 1'b1) begin n_err++; $display("FAIL old_done got %0b/%0b want 0/1", we, idle); end
  endtask

  task automatic test_x0_discard();
    drive_pipe(1, 5'd0, 32'hFFFF_FFFF); drive_lsu(1, 5'd0, 32'h5555); q_addr1 = 5'd0;
    tick();
    drive_pipe(0, 0, 0); drive_lsu(0, 0, 0); #1;
    n_cmp++; if (pipe_ready !== 1'b1 || idle !== 1'b1) begin n_err++; $display("FAIL x0_buf got ready=%0b idle=%0b want 1/1", pipe_ready, idle); end
    n_cmp++; if (q_hit1 !== 1'b0 || q_data1 !== 32'd0) begin n_err++; $display("FAIL x0_fwd got %0b/%h want 0/0", q_hit1, q_data1); end
    tick();
    n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL x0_we got %0b want 0", we); end
  endtask

  task automatic test_rdy_freeze();
    drive_pipe(1, 5'd4, 32'h44); drive_lsu(1, 5'd6, 32'h66);
    tick();
    drive_pipe(0, 0, 0); drive_lsu(0, 0, 0);
    tick();
    rdy = 1'b0; drive_pipe(1, 5'd2, 32'h22); q_addr1 = 5'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (pipe_ready !== 1'b0 || lsu_ready !== 1'b0) begin n_err++; $display("FAIL frz_ready%0d got %0b%0b want 00", i, pipe_ready, lsu_ready); end
      n_cmp++; if (we !== 1'b1 || waddr !== 5'd6 || wdata !== 32'h66) begin n_err++; $display("FAIL frz_hold%0d got %0b/%0d/%h want 1/6/66", i, we, waddr, wdata); end
      n_cmp++; if (q_hit1 !== 1'b1 || q_data1 !== 32'h44) begin n_err++; $display("FAIL frz_fwd%0d got %0b/%h want 1/44", i, q_hit1, q_data1); end
      tick();
    end
    rdy = 1'b1; #1;
    n_cmp++; if (pipe_ready !== 1'b1) begin n_err++; $display("FAIL frz_resume_ready got %0b want 1", pipe_ready); end
    tick();
    drive_pipe(0, 0, 0); #1;
    n_cmp++; if (we !== 1'b1 || waddr !== 5'd4 || wdata !== 32'h44) begin n_err++; $display("FAIL frz_w0 got %0b/%0d/%h want 1/4/44", we, waddr, wdata); end
    tick();
    n_cmp++; if (we !== 1'b1 || waddr !== 5'd2 || wdata !== 32'h22) begin n_err++; $display("FAIL frz_w1 got %0b/%0d/%h want 1/2/22", we, waddr, wdata); end
    tick();
    n_cmp++; if (we !== 1'b0 || idle !== 1'b1) begin n_err++; $display("FAIL frz_done got %0b/%0b want 0/1", we, idle); end
    q_addr1 = '0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive_pipe(1, 5'(10 + i), 32'(100 + i)); #1;
      n_cmp++; if (pipe_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready%0d got %0b want 1", i, pipe_ready); end
      tick();
      if (i > 0) begin
        n_cmp++; if (we !== 1'b1 || waddr !== 5'(9 + i) || wdata !== 32'(99 + i)) begin n_err++; $display("FAIL b2b_w%0d got %0b/%0d/%0d want 1/%0d/%0d", i, we, waddr, wdata, 9 + i, 99 + i); end
      end
    end
    drive_pipe(0, 0, 0);
    tick();
    n_cmp++; if (we !== 1'b1 || waddr !== 5'd13 || wdata !== 32'd103) begin n_err++; $display("FAIL b2b_last got %0b/%0d/%0d want 1/13/103", we, waddr, wdata); end
    tick();
    n_cmp++; if (we !== 1'b0 || idle !== 1'b1) begin n_err++; $display("FAIL b2b_done got %0b/%0b want 0/1", we, idle); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_op();
    test_lone_pipe();
    test_contention();
    test_oldest_first();
    test_x0_discard();
    test_rdy_freeze();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: the in-order pipeline (MEM/WB result) and the load/store unit (load data returning from the memory controller).
- Each source has a one-entry holding buffer. Grants go oldest-first. The granted entry is driven onto registered we/waddr/wdata that feed the register file write port.
- Two forwarding query ports let decode read values still held in the buffers, so it does not need to stall for them.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (x0..x31)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes all state
- pipe_valid  in  1  pipeline writeback request
- pipe_ready  out  1  pipeline buffer can accept this cycle
- pipe_waddr  in  ADDR_W  pipeline destination register
- pipe_wdata  in  DATA_W  pipeline result
- lsu_valid  in  1  LSU writeback request
- lsu_ready  out  1  LSU buffer can accept this cycle
- lsu_waddr  in  ADDR_W  LSU destination register
- lsu_wdata  in  DATA_W  LSU load data
- we  out  1  register file write enable (registered)
- waddr  out  ADDR_W  register file write address (registered)
- wdata  out  DATA_W  register file write data (registered)
- q_addr1  in  ADDR_W  forward query 1 address
- q_hit1  out  1  query 1 matches a buffered entry
- q_data1  out  DATA_W  query 1 forwarded data
- q_addr2  in  ADDR_W  forward query 2 address
- q_hit2  out  1  query 2 matches a buffered entry
- q_data2  out  DATA_W  query 2 forwarded data
- idle  out  1  both buffers empty and we=0

Behaviour:
- Reset (rst=1 at posedge): both buffers invalid; age flag=0; we=0, waddr=0, wdata=0. Outputs pipe_ready, lsu_ready, q_hit*, q_data* read 0 while rst=1.
- rdy=0: no accept, no grant, no state change. pipe_ready=lsu_ready=0. we/waddr/wdata hold their values, because the register file ignores writes while rdy=0.
- Grant is combinational from state only (buffer valids and age flag), never from *_valid inputs:
  - one buffer valid -> grant it
  - both valid -> grant the older buffer
  - both valid and accepted in the same cycle -> LSU first, pipeline treated as the newer write
- Ready: src_ready = rdy && (!buf_valid || grant==src). No combinational path from *_valid to *_ready.
- Accept: at a posedge with valid && ready, capture addr/data and set buf_valid.
  - waddr==0 is accepted and discarded: the buffer stays invalid and nothing is ever written.
- Output register, at each posedge with rdy=1:
  - grant present -> we=1, waddr/wdata = granted entry; granted buffer clears unless refilled the same edge.
  - no grant -> we=0, waddr/wdata hold.
- Age flag: set when an entry enters while the other buffer already holds a valid entry; records which buffer is older; cleared when either buffer empties.
- Latency: accept at edge N -> we=1 during cycle N+1 -> register file writes at edge N+2.
- Throughput: one write per cycle sustained. Each source may issue every cycle while uncontested. A stalled source sees ready=0 only while its buffer is valid and not granted.
- Forwarding (combinational), per query address q:
  - q==0 -> hit=0, data=0.
  - Otherwise match against the valid buffers. If both match, return the newer per the age/tie rule.
  - No match -> hit=0, data=0.
  - The output register is not searched; the register file bypasses its own write port.
- Simultaneous accept and grant on the same buffer in one edge is legal and must not lose either entry.

Decomposition:
- Shared defines: WriteEnable, ZeroWord, RegAddrBus/RegBus widths, RegNumLog2. Add a WbSrcPipe/WbSrcLsu encoding constant for the grant and age logic.
- One natural sub-module, wb_hold_buf: a single-entry valid/addr/data buffer with accept/clear and an address-compare output. Instantiated twice.

Test Plan:
- Reset mid-operation: both buffers full, assert rst one cycle -> next cycle we=0, idle=1, pipe_ready=lsu_ready=1.
- Lone pipe write: pipe x5=0x0000_1234 at edge N -> we=1, waddr=5, wdata=0x1234 in cycle N+1; idle=1 by cycle N+2.
- Contention with same-cycle accept: pipe x3=0xAAAA and lsu x3=0xBBBB at the same edge -> LSU written first, then pipe; x3 finally 0xAAAA. q_addr1=3 returns 0xAAAA in the gap cycle.
- Oldest-first order: LSU x7=1 at N, pipe x8=2 at N+1 while LSU is blocked by an earlier pipe entry -> writes issue in acceptance order; no entry lost or duplicated.
- x0 discard: pipe x0=0xFFFF_FFFF -> we stays 0; pipe_ready stays 1; q_hit1=0 for q_addr1=0.
- rdy freeze: drop rdy for 3 cycles with we=1 pending -> we/waddr/wdata held, both readys 0; resumes exactly one write per cycle after rdy returns.
